count_seq_checker: RTL
======================

// Module: count_seq_checker
// PURPOSE
//  Consumer-side monitor for the free-running up counter's `out` bus.
//  Samples the count each qualified clk edge and checks that it advances by
//  exactly +1 modulo 2^WIDTH. Locks onto the sequence, then flags breaks,
//  counts errors and counts wrap-arounds.
//  Sits beside the counter in sim and on silicon as a self-check.
// PARAMETERS
//  WIDTH     3   width of the monitored count bus
//  LOCK_CNT  2   consecutive good increments required to enter LOCKED (>=1)
//  ERR_W     8   width of err_cnt and wrap_cnt (both saturating)
// PORTS
//  clk       in   1        single clock; all state updates on posedge
//  Rst       in   1        asynchronous reset, active-high
//  cnt_in    in   WIDTH    count value under check (settled before posedge)
//  en        in   1        sample-valid qualifier; en=0 -> hold all state
//  sync_rst  in   1        counter reset being driven; resync without error
//  clr       in   1        synchronous clear of err_cnt and wrap_cnt
//  locked    out  1        high while FSM is in LOCKED
//  err_pulse out  1        one-cycle pulse per detected sequence break
//  err_cnt   out  ERR_W    saturating count of sequence breaks
//  wrap_cnt  out  ERR_W    saturating count of all-ones -> 0 transitions
//  exp_next  out  WIDTH    next expected value (prev + 1, mod 2^WIDTH)
// BEHAVIOUR
//  Reset (Rst=1, async): state=IDLE, prev=0, good=0, locked=0, err_pulse=0,
//   err_cnt=0, wrap_cnt=0, exp_next=1.
//  All outputs registered; result of sample at edge N is visible after edge N.
//  "match" = (cnt_in == prev + 1) mod 2^WIDTH; prev <= cnt_in on every en.
//  FSM, evaluated only when en=1 (en=0: hold everything, err_pulse=0):
//   IDLE   : capture prev, good<=0 -> SYNC. No checking.
//   SYNC   : match: good++; if good+1==LOCK_CNT -> LOCKED, good<=0.
//            mismatch: good<=0, stay SYNC, no error (not yet locked).
//   LOCKED : match: stay; if prev==all-ones and cnt_in==0, wrap_cnt++.
//            mismatch: err_pulse=1 for 1 cycle, err_cnt++, good<=0 -> SYNC.
//  sync_rst=1 (sync, en-independent): state->IDLE, good<=0, locked<=0,
//   no err_pulse; err_cnt/wrap_cnt unchanged. Beats FSM update same cycle.
//  clr=1: err_cnt<=0, wrap_cnt<=0; beats same-cycle increment (result 0).
//   FSM and err_pulse are unaffected by clr.
//  Saturation: err_cnt and wrap_cnt stop at 2^ERR_W-1, no wrap.
//  Rst mid-operation: immediate return to reset values, any FSM state.
//  Width rule: prev+1 computed in WIDTH bits (all-ones+1 == 0).
// TESTING (WIDTH=3, LOCK_CNT=2 unless stated)
//  1 Rst=1 from any state -> locked=0, err_cnt=0, wrap_cnt=0, err_pulse=0
//    immediately, without waiting for a clk edge.
//  2 en=1, cnt_in 0,1,2,3 -> locked rises after the edge sampling 2,
//    stays high at 3; exp_next=4.
//  3 locked; cnt_in 6,7,0,1 -> wrap_cnt=1 after the edge sampling 0;
//    err_pulse stays 0.
//  4 locked at 3; cnt_in 5 -> err_pulse high exactly 1 cycle, err_cnt=1,
//    locked=0; then 6,7 -> locked high again after 7.
//  5 locked at 4; sync_rst=1 with cnt_in=0 -> locked=0, err_pulse=0,
//    err_cnt unchanged; then 1,2,3 -> relock after 2 increments.
//  6 ERR_W=2: inject 5 breaks -> err_cnt holds 3. clr=1 in the same cycle
//    as a break -> err_cnt=0 and err_pulse=1.

Source files
------------

// File: rtl/count_seq_checker.sv
// Watches a free-running up-counter bus, locks onto its +1 sequence, then flags
// and counts sequence breaks and counts all-ones -> 0 wrap-arounds.
module count_seq_checker #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             en,
  input  logic             sync_rst,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0] exp_next
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0]    LOCK_V  = GW'(LOCK_CNT);
  localparam logic [WIDTH-1:0] ALL1    = {WIDTH{1'b1}};
  localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [GW-1:0]    good_q, good_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic [WIDTH-1:0] prev_inc;
  logic [GW-1:0]    good_inc;
  logic             match;
  logic             err_inc;
  logic             wrap_inc;

  assign prev_inc = prev_q + WIDTH'(1);
  assign good_inc = good_q + GW'(1);
  assign match    = (cnt_in == prev_inc);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    good_d      = good_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    wrap_inc    = 1'b0;

    if (en) begin
      prev_d = cnt_in;
      case (state_q)
        IDLE: begin
          good_d  = '0;
          state_d = SYNC;
        end
        SYNC: begin
          // Breaks before lock are expected during start-up, so no error here.
          if (match) begin
            if (good_inc == LOCK_V) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_inc;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            wrap_inc = (prev_q == ALL1) && (cnt_in == '0);
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            good_d      = '0;
            state_d     = SYNC;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Counter reset is a legitimate discontinuity: resync silently.
    if (sync_rst) begin
      state_d     = IDLE;
      good_d      = '0;
      err_pulse_d = 1'b0;
      err_inc     = 1'b0;
      wrap_inc    = 1'b0;
    end

    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    if (err_inc && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
    if (wrap_inc && (wrap_cnt_q != CNT_MAX)) begin
      wrap_cnt_d = wrap_cnt_q + ERR_W'(1);
    end
    if (clr) begin
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      good_q      <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      good_q      <= good_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign exp_next  = prev_inc;

endmodule
